serial_nibble_rx: RTL and testbench



---
 rtl/serial_pkg.sv | 26 ++
 rtl/rx_out_buf.sv | 70 +++++++
 rtl/serial_nibble_rx.sv | 149 ++++++++++++++
 tb/tb_serial_nibble_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial deframer slice: the receiver FSM state
// encoding, the serial line levels and a small start-detect helper.
// No ports (package).
// Optional feature macro used by importers: SERIAL_NIBBLE_RX_PARITY_EN.
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b0;

  // A start bit is the line leaving its idle level towards the start level.
  function automatic logic is_start(input logic s);
    return (s == START_LEVEL) && (s != IDLE_LEVEL);
  endfunction

endpackage

// File: rtl/rx_out_buf.sv
// ---------------------------------------------------------------------------
// rx_out_buf
// Single-entry valid/ready output register for received words, with sticky
// overrun detection when a new word arrives while the old one is unconsumed.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   commit     a good frame completed this cycle; data holds its word
//   data       word to load on commit
//   out_ready  consumer accepts Q this cycle
//   Q          buffered word (held stable while out_valid && !out_ready)
//   out_valid  Q holds an unconsumed word
//   overrun    sticky: a committed word was dropped (cleared by reset only)
// ---------------------------------------------------------------------------
module rx_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic             xfer;

  assign xfer = valid_reg && out_ready;

  always_comb begin
    q_next       = q_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (xfer) begin
      valid_next = 1'b0;
    end
    if (commit) begin
      // The slot is free if empty or being drained this very cycle, which
      // lets back-to-back words flow with no bubble.
      if (!valid_reg || out_ready) begin
        q_next     = data;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg       <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign Q         = q_reg;
  assign out_valid = valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/serial_nibble_rx.sv
// ---------------------------------------------------------------------------
// serial_nibble_rx
// Deframes a one-bit-per-clock serial stream (start 1, WIDTH data bits,
// [even parity bit], stop 0) into WIDTH-bit words presented on a
// valid/ready output buffer.
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   sin         serial line, idle level 0
//   out_ready   consumer accepts Q this cycle
//   Q           received word
//   out_valid   Q holds an unconsumed word
//   frame_err   one-cycle pulse: stop bit sampled as 1
//   overrun     sticky: a completed frame was dropped
//   busy        FSM not in IDLE
//   parity_err  (only with SERIAL_NIBBLE_RX_PARITY_EN) one-cycle pulse on a
//               parity mismatch
// Macro SERIAL_NIBBLE_RX_PARITY_EN inserts the PARITY state and parity_err.
// ---------------------------------------------------------------------------
module serial_nibble_rx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  output logic             frame_err,
  output logic             overrun,
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_e        state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] asm_reg;
  logic             frame_err_reg;
  logic             stop_ok;
  logic             commit;

  assign stop_ok = (sin == STOP_LEVEL);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (is_start(sin)) begin
          state_next = DATA;
          cnt_next   = '0;
        end
      end
      DATA: begin
        // Counter ends at WIDTH on the last data bit and is only cleared by
        // the next start bit, so it never wraps inside a frame.
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_BIT) begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY:  state_next = STOP;
      // The stop cycle always returns to IDLE; a bad stop bit is never
      // taken as the next start bit.
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      frame_err_reg <= (state_reg == STOP) && !stop_ok;
    end
  end

  // Each assembly bit captures sin on the data slot that maps to it, which
  // gives the same result as shifting in the chosen direction.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_asm
      localparam logic [CW-1:0] SLOT = LSB_FIRST ? CW'(gi) : CW'(WIDTH - 1 - gi);
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          asm_reg[gi] <= 1'b0;
        end else if ((state_reg == DATA) && (cnt_reg == SLOT)) begin
          asm_reg[gi] <= sin;
        end
      end
    end
  endgenerate

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  logic par_bad_reg;
  logic parity_err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      // Even parity: data bits plus parity bit must hold an even count of ones.
      if (state_reg == PARITY) begin
        par_bad_reg <= (^asm_reg) ^ sin;
      end
      parity_err_reg <= (state_reg == STOP) && par_bad_reg;
    end
  end

  assign parity_err = parity_err_reg;
  assign commit     = (state_reg == STOP) && stop_ok && !par_bad_reg;
`else
  assign commit     = (state_reg == STOP) && stop_ok;
`endif

  rx_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .commit    (commit),
    .data      (asm_reg),
    .out_ready (out_ready),
    .Q         (Q),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  assign frame_err = frame_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_nibble_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_nibble_rx
// Drives framed words into an LSB-first and an MSB-first receiver sharing
// the same serial line and handshake, and checks every cycle against a
// frame-level reference: a one-deep queue for the output buffer, a sticky
// overrun flag and the expected error pulses of each frame sent.
// Honours SERIAL_NIBBLE_RX_PARITY_EN (adds parity bits and parity_err).
// ---------------------------------------------------------------------------
module tb_serial_nibble_rx;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         sin;
  logic         out_ready;
  logic [W-1:0] q_lsb, q_msb;
  logic         valid_lsb, valid_msb;
  logic         fe_lsb, fe_msb;
  logic         ov_lsb, ov_msb;
  logic         busy_lsb, busy_msb;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  logic         pe_lsb, pe_msb;
`endif

  serial_nibble_rx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .out_ready  (out_ready),
    .Q          (q_lsb),
    .out_valid  (valid_lsb),
    .frame_err  (fe_lsb),
    .overrun    (ov_lsb),
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    .parity_err (pe_lsb),
`endif
    .busy       (busy_lsb)
  );

  serial_nibble_rx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .out_ready  (out_ready),
    .Q          (q_msb),
    .out_valid  (valid_msb),
    .frame_err  (fe_msb),
    .overrun    (ov_msb),
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    .parity_err (pe_msb),
`endif
    .busy       (busy_msb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference state
  logic [W-1:0] buf_q[$];
  logic [W-1:0] q_last;
  logic         ov_m;
  logic         fe_m;
  logic         pe_m;
  logic         busy_m;

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("out_valid", {31'd0, valid_lsb}, {31'd0, (buf_q.size() != 0)});
    chk("out_valid_msb", {31'd0, valid_msb}, {31'd0, (buf_q.size() != 0)});
    chk("Q_lsb", {28'd0, q_lsb}, {28'd0, q_last});
    chk("Q_msb", {28'd0, q_msb}, {28'd0, rev(q_last)});
    chk("overrun", {31'd0, ov_lsb}, {31'd0, ov_m});
    chk("frame_err", {31'd0, fe_lsb}, {31'd0, fe_m});
    chk("frame_err_msb", {31'd0, fe_msb}, {31'd0, fe_m});
    chk("busy", {31'd0, busy_lsb}, {31'd0, busy_m});
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    chk("parity_err", {31'd0, pe_lsb}, {31'd0, pe_m});
`endif
  endtask

  // One clock: drive the line and ready, then describe what the frame
  // protocol says must be visible after the edge.
  task automatic tick(input logic s, input logic r, input logic commit_ev,
                      input logic fe_ev, input logic pe_ev,
                      input logic [W-1:0] w, input logic busy_after);
    logic had;
    sin       = s;
    out_ready = r;
    had       = (buf_q.size() != 0);
    @(posedge clk);
    #1;
    if (had && r) begin
      $display("xfer  word=%h", buf_q[0]);
      void'(buf_q.pop_front());
    end
    if (commit_ev) begin
      if (!had || r) begin
        buf_q.push_back(w);
        q_last = w;
      end else begin
        ov_m = 1'b1;
      end
    end
    fe_m   = fe_ev;
    pe_m   = pe_ev;
    busy_m = busy_after;
    check_all();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) tick(1'b0, r, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Frame carrying word w (bit 0 sent first), stop bit value stop_bit,
  // ready r_body during the frame and r_stop in the stop cycle.
  task automatic send_frame(input logic [W-1:0] w, input logic stop_bit,
                            input logic r_body, input logic r_stop,
                            input logic par_flip);
    logic flip_eff;
    logic good;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    flip_eff = par_flip;
`else
    flip_eff = 1'b0;
`endif
    tick(1'b1, r_body, 1'b0, 1'b0, 1'b0, w, 1'b1);
    for (int i = 0; i < W; i++) tick(w[i], r_body, 1'b0, 1'b0, 1'b0, w, 1'b1);
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    tick((^w) ^ flip_eff, r_body, 1'b0, 1'b0, 1'b0, w, 1'b1);
`endif
    good = (stop_bit == 1'b0) && !flip_eff;
    tick(stop_bit, r_stop, good, stop_bit, flip_eff, w, 1'b0);
    $display("frame word=%h stop=%0d parflip=%0d good=%0d overrun=%0d",
             w, stop_bit, flip_eff, good, ov_m);
  endtask

  initial begin
    logic [W-1:0] rw;
    logic         rbad, rflip, rb, rs;

    reset     = 1'b0;
    sin       = 1'b0;
    out_ready = 1'b0;
    q_last    = '0;
    ov_m      = 1'b0;
    fe_m      = 1'b0;
    pe_m      = 1'b0;
    busy_m    = 1'b0;

    #12;
    check_all();
    reset = 1'b1;

    // Basic receive, immediate consumption
    send_frame(4'hD, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Bad stop bit, then a good frame right after recovery
    send_frame(4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    send_frame(4'hA, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);

    // Overrun: consumer stalled across two back-to-back frames
    send_frame(4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Commit coinciding with a transfer: valid stays high, A then 5
    send_frame(4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Asynchronous reset pulse in the middle of DATA
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    buf_q.delete();
    q_last = '0;
    ov_m   = 1'b0;
    fe_m   = 1'b0;
    pe_m   = 1'b0;
    busy_m = 1'b0;
    check_all();
    #2;
    reset = 1'b1;
    send_frame(4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    send_frame(4'h6, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    send_frame(4'h9, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
`endif

    // Randomised traffic: words, errors, stalls and gaps
    for (int n = 0; n < 60; n++) begin
      rw    = W'($urandom_range(0, (1 << W) - 1));
      rbad  = ($urandom_range(0, 7) == 0);
      rflip = ($urandom_range(0, 5) == 0);
      rb    = 1'($urandom_range(0, 1));
      rs    = 1'($urandom_range(0, 1));
      send_frame(rw, rbad, rb, rs, rflip);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        idle(1, 1'($urandom_range(0, 1)));
      end
    end
    idle(2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
